// File: rtl/xm_ctrl_pkg.sv
// Shared encodings for the XMakina control path: macro-ops, sequencer state
// indices, condition codes and PSW flag positions.
package xm_ctrl_pkg;

    typedef enum logic [2:0] {
        BRANCH_W_LINK      = 3'd0,
        CONDITIONAL_BRANCH = 3'd1,
        ALU_OPERATION      = 3'd2,
        CONDITIONAL_EXEC   = 3'd3,
        SYSTEM_CALL        = 3'd4,
        LOAD               = 3'd5,
        STORE              = 3'd6,
        IMMEDIATE_MOVE     = 3'd7
    } MACRO_OPS;

    typedef enum logic [3:0] {
        INIT          = 4'd0,
        FETCH         = 4'd1,
        WAIT_FETCH    = 4'd2,
        DECODE        = 4'd3,
        OPERAND_FETCH = 4'd4,
        EXECUTE       = 4'd5,
        NOP_EXECUTE   = 4'd6,
        MEMORY_ACCESS = 4'd7,
        WRITE_BACK    = 4'd8,
        FAULT         = 4'd9
    } EXECUTION_STATES;

    typedef enum logic [2:0] {
        EQ = 3'd0,
        NE = 3'd1,
        CS = 3'd2,
        CC = 3'd3,
        MI = 3'd4,
        GE = 3'd5,
        LT = 3'd6,
        AL = 3'd7
    } COND_CODES;

    localparam int PSW_C = 0;
    localparam int PSW_Z = 1;
    localparam int PSW_N = 2;
    localparam int PSW_V = 3;

    localparam int NUM_STATES = 10;

    // One-hot vector with only the given state's bit set.
    function automatic logic [NUM_STATES-1:0] st_bit(input EXECUTION_STATES s);
        st_bit    = '0;
        st_bit[s] = 1'b1;
    endfunction

endpackage

// File: rtl/xm_cond_eval.sv
// Evaluates a 3-bit condition code against the C/Z/N/V flags of the PSW.
module xm_cond_eval
    import xm_ctrl_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_true
);

    always_comb begin
        o_true = 1'b1;
        case (i_cond)
            EQ:      o_true = i_flags[PSW_Z];
            NE:      o_true = ~i_flags[PSW_Z];
            CS:      o_true = i_flags[PSW_C];
            CC:      o_true = ~i_flags[PSW_C];
            MI:      o_true = i_flags[PSW_N];
            GE:      o_true = (i_flags[PSW_N] == i_flags[PSW_V]);
            LT:      o_true = (i_flags[PSW_N] != i_flags[PSW_V]);
            default: o_true = 1'b1;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: one-hot FSM with memory handshake,
// fetch/memory timeouts, CEX execute/skip windows and a retire pulse.
module exec_sequencer
    import xm_ctrl_pkg::*;
#(
    parameter int unsigned DEBUG      = 0,
    parameter int unsigned CEX_CNT_W  = 3,
    parameter int unsigned TIMEOUT_EN = 1,
    parameter int unsigned TIMEOUT_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_done,
    input  logic [2:0]           macro_op,
    input  logic                 branch_en,
    input  logic [2:0]           branch_cond,
    input  logic [2:0]           cex_cond,
    input  logic [CEX_CNT_W-1:0] cex_true_cnt,
    input  logic [CEX_CNT_W-1:0] cex_false_cnt,
    input  logic                 new_status_en,
    input  logic [1:0]           reg_wb_mode,
    input  logic [15:0]          status_reg,
    input  logic                 mem_ack,
    input  logic                 fault_clr,
    output logic                 fetch_en,
    output logic                 pc_fetch_wr,
    output logic                 pc_branch_wr,
    output logic                 decode_en,
    output logic                 alu_in_en,
    output logic                 alu_out_en,
    output logic                 status_wr,
    output logic [1:0]           reg_wr_en,
    output logic                 mem_req,
    output logic                 mem_wr,
    output logic                 instr_retired,
    output logic                 fault,
    output logic [9:0]           exec_state_reg
);

    // Counter value seen in the last allowed cycle of a wait state.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

    logic [NUM_STATES-1:0] r_state;
    logic [TIMEOUT_W-1:0]  r_tmo_cnt;
    logic [CEX_CNT_W-1:0]  r_cnt_a;
    logic [CEX_CNT_W-1:0]  r_cnt_b;
    logic                  r_exec_a;
    logic                  r_nop_retire;

    logic w_branch_true;
    logic w_cex_true;
    logic w_tmo_hit;
    logic w_in_a;
    logic w_in_b;
    logic w_skip;
    logic w_is_cex;
    logic w_is_mem;
    logic w_unused_psw;

    xm_cond_eval u_branch_cond (
        .i_cond  (branch_cond),
        .i_flags (status_reg[3:0]),
        .o_true  (w_branch_true)
    );

    xm_cond_eval u_cex_cond (
        .i_cond  (cex_cond),
        .i_flags (status_reg[3:0]),
        .o_true  (w_cex_true)
    );

    assign w_unused_psw = ^status_reg[15:4];
    assign w_tmo_hit    = (TIMEOUT_EN != 0) && (r_tmo_cnt == TMO_LAST);
    assign w_in_a       = (r_cnt_a != '0);
    assign w_in_b       = !w_in_a && (r_cnt_b != '0);
    // Phase B always runs in the opposite mode of phase A.
    assign w_skip       = (w_in_a && !r_exec_a) || (w_in_b && r_exec_a);
    assign w_is_cex     = (macro_op == CONDITIONAL_EXEC);
    assign w_is_mem     = (macro_op == LOAD) || (macro_op == STORE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= st_bit(INIT);
            r_tmo_cnt    <= '0;
            r_cnt_a      <= '0;
            r_cnt_b      <= '0;
            r_exec_a     <= 1'b0;
            r_nop_retire <= 1'b0;
        end else begin
            unique case (1'b1)
                r_state[INIT]: r_state <= st_bit(FETCH);
                r_state[FETCH]: begin
                    r_state   <= st_bit(WAIT_FETCH);
                    r_tmo_cnt <= '0;
                end
                r_state[WAIT_FETCH]: begin
                    if (fetch_done)     r_state <= st_bit(DECODE);
                    else if (w_tmo_hit) r_state <= st_bit(FAULT);
                    else                r_tmo_cnt <= r_tmo_cnt + TIMEOUT_W'(1);
                end
                r_state[DECODE]: r_state <= st_bit(OPERAND_FETCH);
                r_state[OPERAND_FETCH]: begin
                    if (w_is_cex && !w_skip) begin
                        r_cnt_a  <= cex_true_cnt;
                        r_cnt_b  <= cex_false_cnt;
                        r_exec_a <= w_cex_true;
                    end else if (w_in_a) begin
                        r_cnt_a <= r_cnt_a - CEX_CNT_W'(1);
                    end else if (w_in_b) begin
                        r_cnt_b <= r_cnt_b - CEX_CNT_W'(1);
                    end
                    r_nop_retire <= !w_skip;
                    if (w_skip || w_is_cex || (macro_op == SYSTEM_CALL))
                        r_state <= st_bit(NOP_EXECUTE);
                    else
                        r_state <= st_bit(EXECUTE);
                end
                r_state[EXECUTE]: begin
                    r_tmo_cnt <= '0;
                    r_state   <= w_is_mem ? st_bit(MEMORY_ACCESS) : st_bit(WRITE_BACK);
                end
                r_state[MEMORY_ACCESS]: begin
                    if (mem_ack)        r_state <= st_bit(WRITE_BACK);
                    else if (w_tmo_hit) r_state <= st_bit(FAULT);
                    else                r_tmo_cnt <= r_tmo_cnt + TIMEOUT_W'(1);
                end
                r_state[WRITE_BACK]:  r_state <= st_bit(FETCH);
                r_state[NOP_EXECUTE]: r_state <= st_bit(FETCH);
                r_state[FAULT]: if (fault_clr) r_state <= st_bit(FETCH);
                default: r_state <= st_bit(INIT);
            endcase
        end
    end

    assign fetch_en      = r_state[FETCH];
    assign pc_fetch_wr   = r_state[DECODE];
    assign decode_en     = r_state[DECODE];
    assign alu_in_en     = r_state[OPERAND_FETCH];
    assign alu_out_en    = r_state[EXECUTE];
    assign pc_branch_wr  = r_state[EXECUTE] & branch_en & w_branch_true;
    assign status_wr     = r_state[WRITE_BACK] & new_status_en;
    assign reg_wr_en     = (r_state[WRITE_BACK] && (macro_op != STORE)) ? reg_wb_mode : 2'b00;
    assign mem_req       = r_state[MEMORY_ACCESS];
    assign mem_wr        = r_state[MEMORY_ACCESS] & (macro_op == STORE);
    assign instr_retired = r_state[WRITE_BACK] | (r_state[NOP_EXECUTE] & r_nop_retire);
    assign fault         = r_state[FAULT];
    // Gated by reset so the debug view reads 0 while reset is held.
    assign exec_state_reg = (DEBUG != 0) ? (r_state & {NUM_STATES{reset}}) : '0;

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomised scoreboard bench for exec_sequencer with a queue-based CEX model.
module tb_exec_sequencer;
    import xm_ctrl_pkg::*;

    localparam int LIM = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic fetch_done = 1'b0;
    logic [2:0] macro_op = '0;
    logic branch_en = 1'b0;
    logic [2:0] branch_cond = '0;
    logic [2:0] cex_cond = '0;
    logic [2:0] cex_true_cnt = '0;
    logic [2:0] cex_false_cnt = '0;
    logic new_status_en = 1'b0;
    logic [1:0] reg_wb_mode = '0;
    logic [15:0] status_reg = '0;
    logic mem_ack = 1'b0;
    logic fault_clr = 1'b0;
    logic fetch_en, pc_fetch_wr, pc_branch_wr, decode_en, alu_in_en, alu_out_en;
    logic status_wr, mem_req, mem_wr, instr_retired, fault;
    logic [1:0] reg_wr_en;
    logic [9:0] exec_state_reg;

    exec_sequencer #(.DEBUG(1), .CEX_CNT_W(3), .TIMEOUT_EN(1), .TIMEOUT_W(4)) dut (
        .clk(clk), .reset(reset), .fetch_done(fetch_done), .macro_op(macro_op),
        .branch_en(branch_en), .branch_cond(branch_cond), .cex_cond(cex_cond),
        .cex_true_cnt(cex_true_cnt), .cex_false_cnt(cex_false_cnt),
        .new_status_en(new_status_en), .reg_wb_mode(reg_wb_mode), .status_reg(status_reg),
        .mem_ack(mem_ack), .fault_clr(fault_clr), .fetch_en(fetch_en),
        .pc_fetch_wr(pc_fetch_wr), .pc_branch_wr(pc_branch_wr), .decode_en(decode_en),
        .alu_in_en(alu_in_en), .alu_out_en(alu_out_en), .status_wr(status_wr),
        .reg_wr_en(reg_wr_en), .mem_req(mem_req), .mem_wr(mem_wr),
        .instr_retired(instr_retired), .fault(fault), .exec_state_reg(exec_state_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op; logic br_en; logic [2:0] br_c; logic [2:0] cx_c;
        logic [2:0] tc; logic [2:0] fc; logic nse; logic [1:0] wb; logic [15:0] psw;
        int fd; int ad; bit abort;
    } stim_t;

    // kind: 0 = write-back, 1 = nop, 2 = fault
    typedef struct {
        int kind; int reg_wr; int st_wr; int ret; int br;
        int mem_cycles; int mem_wr; int wait_cycles; int strobes;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    bit    exec_q[$];   // per upcoming instruction: 1 = execute, 0 = skip
    int    checks = 0;
    int    failures = 0;
    int    txn = 0;
    int    cur_fd = 1;
    int    cur_ad = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic bit cond_ok(input logic [2:0] c, input logic [15:0] p);
        bit cf, z, n, v;
        cf = p[0]; z = p[1]; n = p[2]; v = p[3];
        case (c)
            3'd0: return z;
            3'd1: return !z;
            3'd2: return cf;
            3'd3: return !cf;
            3'd4: return n;
            3'd5: return n == v;
            3'd6: return n != v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic stim_t mk(input logic [2:0] op, input logic br_en, input logic [2:0] br_c,
                                 input logic [2:0] cx_c, input logic [2:0] tc, input logic [2:0] fc,
                                 input logic nse, input logic [1:0] wb, input logic [15:0] psw,
                                 input int fd, input int ad);
        stim_t s;
        s.op = op; s.br_en = br_en; s.br_c = br_c; s.cx_c = cx_c; s.tc = tc; s.fc = fc;
        s.nse = nse; s.wb = wb; s.psw = psw; s.fd = fd; s.ad = ad; s.abort = 1'b0;
        return s;
    endfunction

    // Reference model: one expected record per fetched instruction.
    task automatic model(input stim_t s);
        exp_t e;
        bit skip, c;
        e = '{default: 0};
        e.wait_cycles = s.fd;
        if (s.fd > LIM) begin
            e.kind = 2; e.wait_cycles = LIM; e.strobes = 10000;
            exp_q.push_back(e);
            return;
        end
        skip = 1'b0;
        if (exec_q.size() > 0) skip = !exec_q.pop_front();
        if (!skip && s.op == CONDITIONAL_EXEC) begin
            c = cond_ok(s.cx_c, s.psw);
            exec_q.delete();
            repeat (int'(s.tc)) exec_q.push_back(c);
            repeat (int'(s.fc)) exec_q.push_back(!c);
        end
        if (skip || s.op == SYSTEM_CALL || s.op == CONDITIONAL_EXEC) begin
            e.kind = 1; e.ret = !skip; e.strobes = 11110;
            exp_q.push_back(e);
            return;
        end
        e.strobes = 11111;
        e.br = (s.br_en && cond_ok(s.br_c, s.psw)) ? 1 : 0;
        if (s.op == LOAD || s.op == STORE) begin
            e.mem_wr = (s.op == STORE) ? 1 : 0;
            if (s.ad + 1 > LIM) begin
                e.kind = 2; e.mem_cycles = LIM;
                exp_q.push_back(e);
                return;
            end
            e.mem_cycles = s.ad + 1;
        end
        e.kind = 0; e.ret = 1; e.st_wr = s.nse;
        e.reg_wr = (s.op == STORE) ? 0 : int'(s.wb);
        exp_q.push_back(e);
    endtask

    // Instruction/fetch responder: presents the next instruction at each fetch.
    initial begin : fetch_rsp
        int wcnt;
        stim_t s;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                fetch_done = 1'b0; wcnt = 0;
            end else if (fetch_en) begin
                fetch_done = 1'b0; wcnt = 0;
                if (stim_q.size() > 0) begin
                    s = stim_q.pop_front();
                    macro_op = s.op; branch_en = s.br_en; branch_cond = s.br_c;
                    cex_cond = s.cx_c; cex_true_cnt = s.tc; cex_false_cnt = s.fc;
                    new_status_en = s.nse; reg_wb_mode = s.wb; status_reg = s.psw;
                    cur_fd = s.fd; cur_ad = s.ad;
                    if (!s.abort) model(s);
                end else begin
                    cur_fd = 1000; cur_ad = 0;
                end
            end else if (exec_state_reg[WAIT_FETCH]) begin
                wcnt++;
                fetch_done = (wcnt == cur_fd);
            end else begin
                fetch_done = 1'b0;
            end
        end
    end

    initial begin : mem_rsp
        int mcnt;
        mcnt = 0;
        forever begin
            @(negedge clk);
            if (reset && mem_req) begin
                mcnt++;
                mem_ack = (mcnt == cur_ad + 1);
            end else begin
                mcnt = 0; mem_ack = 1'b0;
            end
        end
    end

    // fault_clr is also toggled outside FAULT, where it must have no effect.
    initial begin : clr_rsp
        forever begin
            @(negedge clk);
            if (!reset)     fault_clr = 1'b0;
            else if (fault) fault_clr = ($urandom % 3 == 0);
            else            fault_clr = ($urandom % 8 == 0);
        end
    end

    initial begin : monitor
        int wait_cnt, mem_cnt, br_cnt, memwr_seen, fe, pcf, dec, ain, aout, got_kind;
        bit prev_fault;
        exp_t e;
        wait_cnt = 0; mem_cnt = 0; br_cnt = 0; memwr_seen = 0;
        fe = 0; pcf = 0; dec = 0; ain = 0; aout = 0; prev_fault = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_fault = 1'b0;
            end else begin
                if (exec_state_reg[FETCH]) begin
                    wait_cnt = 0; mem_cnt = 0; br_cnt = 0; memwr_seen = 0;
                    fe = 0; pcf = 0; dec = 0; ain = 0; aout = 0;
                end
                if (exec_state_reg[WAIT_FETCH]) wait_cnt++;
                if (mem_req) mem_cnt++;
                if (mem_wr) memwr_seen = 1;
                if (pc_branch_wr) br_cnt++;
                fe += int'(fetch_en); pcf += int'(pc_fetch_wr); dec += int'(decode_en);
                ain += int'(alu_in_en); aout += int'(alu_out_en);
                if (exec_state_reg[WRITE_BACK] || exec_state_reg[NOP_EXECUTE] ||
                    (exec_state_reg[FAULT] && !prev_fault)) begin
                    got_kind = exec_state_reg[WRITE_BACK] ? 0 : (exec_state_reg[NOP_EXECUTE] ? 1 : 2);
                    txn++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", got_kind, -1);
                    end else begin
                        e = exp_q.pop_front();
                        $display("txn %0d kind=%0d reg_wr=%0d st_wr=%0d ret=%0d br=%0d mem=%0d wait=%0d",
                                 txn, got_kind, reg_wr_en, status_wr, instr_retired, br_cnt, mem_cnt, wait_cnt);
                        chk("kind", got_kind, e.kind);
                        if (got_kind == e.kind) begin
                            chk("strobes", fe*10000 + pcf*1000 + dec*100 + ain*10 + aout, e.strobes);
                            chk("wait_cycles", wait_cnt, e.wait_cycles);
                            chk("branch_wr", br_cnt, e.br);
                            chk("mem_cycles", mem_cnt, e.mem_cycles);
                            chk("mem_wr", memwr_seen, e.mem_wr);
                            chk("fault", int'(fault), (e.kind == 2) ? 1 : 0);
                            chk("reg_wr_en", int'(reg_wr_en), e.reg_wr);
                            chk("status_wr", int'(status_wr), e.st_wr);
                            chk("retired", int'(instr_retired), e.ret);
                            if (e.kind == 2)
                                chk("fault_quiet", int'({fetch_en, pc_fetch_wr, pc_branch_wr, decode_en,
                                    alu_in_en, alu_out_en, mem_req, mem_wr}), 0);
                        end
                    end
                end
                prev_fault = exec_state_reg[FAULT];
            end
        end
    end

    function automatic int all_outs();
        return int'({fetch_en, pc_fetch_wr, pc_branch_wr, decode_en, alu_in_en, alu_out_en,
                     status_wr, reg_wr_en, mem_req, mem_wr, instr_retired, fault});
    endfunction

    initial begin : main
        stim_t s;
        int cyc;
        // directed scenarios
        stim_q.push_back(mk(ALU_OPERATION, 0, 0, 0, 0, 0, 1, 2'b01, 16'h0000, 2, 0));
        stim_q.push_back(mk(CONDITIONAL_BRANCH, 1, EQ, 0, 0, 0, 0, 2'b00, 16'h0002, 1, 0));
        stim_q.push_back(mk(CONDITIONAL_BRANCH, 1, EQ, 0, 0, 0, 0, 2'b00, 16'h0000, 1, 0));
        stim_q.push_back(mk(STORE, 0, 0, 0, 0, 0, 0, 2'b11, 16'h0000, 1, 5));
        stim_q.push_back(mk(LOAD, 0, 0, 0, 0, 0, 1, 2'b10, 16'h0000, 1, 14));
        stim_q.push_back(mk(LOAD, 0, 0, 0, 0, 0, 1, 2'b10, 16'h0000, 1, 15));
        stim_q.push_back(mk(ALU_OPERATION, 0, 0, 0, 0, 0, 1, 2'b01, 16'h0000, 20, 0));
        stim_q.push_back(mk(ALU_OPERATION, 0, 0, 0, 0, 0, 0, 2'b11, 16'h0000, 15, 0));
        stim_q.push_back(mk(CONDITIONAL_EXEC, 0, 0, NE, 3'd2, 3'd1, 0, 2'b00, 16'h0000, 1, 0));
        for (int i = 0; i < 4; i++)
            stim_q.push_back(mk(ALU_OPERATION, 0, 0, 0, 0, 0, 1, 2'b01, 16'h0000, 1, 0));
        stim_q.push_back(mk(SYSTEM_CALL, 1, AL, 0, 0, 0, 1, 2'b11, 16'h0000, 1, 0));
        // randomised instructions
        for (int i = 0; i < 70; i++) begin
            s = mk(3'($urandom_range(0, 7)), 1'($urandom), 3'($urandom), 3'($urandom),
                   3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 1'($urandom),
                   2'($urandom), 16'($urandom),
                   ($urandom % 12 == 0) ? (($urandom % 2 == 0) ? 15 : 20) : int'($urandom_range(1, 4)),
                   ($urandom % 12 == 0) ? (($urandom % 2 == 0) ? 14 : 15) : int'($urandom_range(0, 5)));
            stim_q.push_back(s);
        end
        // drain any CEX window, then a store that never gets an ack
        for (int i = 0; i < 15; i++)
            stim_q.push_back(mk(ALU_OPERATION, 0, 0, 0, 0, 0, 0, 2'b00, 16'h0000, 1, 0));
        s = mk(STORE, 0, 0, 0, 0, 0, 0, 2'b00, 16'h0000, 1, 100);
        s.abort = 1'b1;
        stim_q.push_back(s);

        repeat (3) @(negedge clk);
        chk("rst_outs", all_outs(), 0);
        chk("rst_state", int'(exec_state_reg), 0);
        reset = 1'b1;
        #1;
        chk("init_state", int'(exec_state_reg), 1 << INIT);
        chk("init_fetch_en", int'(fetch_en), 0);
        @(negedge clk);
        chk("first_fetch_en", int'(fetch_en), 1);

        cyc = 0;
        while (cyc < 40000 && !(mem_req && stim_q.size() == 0 && exp_q.size() == 0)) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_abort_store", int'(cyc < 40000), 1);

        repeat (2) @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_mem_req", int'(mem_req), 0);
        chk("async_outs", all_outs(), 0);
        chk("async_state", int'(exec_state_reg), 0);
        exec_q.delete();
        stim_q.push_back(mk(ALU_OPERATION, 0, 0, 0, 0, 0, 1, 2'b10, 16'h0000, 1, 0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reinit_state", int'(exec_state_reg), 1 << INIT);
        @(negedge clk);
        chk("refetch_en", int'(fetch_en), 1);

        cyc = 0;
        while (cyc < 200 && (stim_q.size() != 0 || exp_q.size() != 0)) begin
            @(negedge clk);
            cyc++;
        end
        chk("final_drain", int'(cyc < 200), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
